clock_compensate_multi: RTL and testbench

- Multi-channel, parametrised successor to the single-lane clock compensator. Runs entirely in the `clk` (init) domain.
- Takes one TX frame-counter and N_CH RX frame-counters, all Gray-coded and already synchronised into `clk`.
- Per channel: classifies TX-vs-RX drift direction, then issues bounded compensation credits through a valid/ready handshake. A downstream CDC carries the credits into each TX frame domain.
- Adds force modes, programmable settle and threshold, and overflow reporting.

---
 rtl/clock_compensate_multi.sv | 170 +++++++++++++++++
 tb/tb_clock_compensate_multi.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_compensate_multi.sv
// Multi-channel clock compensator: compares one TX frame counter against N_CH RX
// counters and issues bounded compensation credits per channel over valid/ready.
module clock_compensate_multi #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned SETTLE   = 64,
  parameter int unsigned THRESH   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [CNT_W-1:0]           tx_cnt_gray,
  input  logic [N_CH*CNT_W-1:0]      rx_cnt_gray,
  output logic [N_CH-1:0]            comp_vld,
  output logic [N_CH*CREDIT_W-1:0]   comp_cnt,
  input  logic [N_CH-1:0]            comp_rdy,
  output logic [N_CH*2-1:0]          comp_type,
  output logic [N_CH-1:0]            overflow
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CLASSIFY,
    ST_TRACK,
    ST_PASSIVE
  } state_t;

  typedef enum logic [1:0] {
    TYPE_UNKNOWN = 2'd0,
    TYPE_YES     = 2'd1,
    TYPE_NO      = 2'd2
  } comp_type_t;

  localparam int unsigned      SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] MAX_GRANT   = CNT_W'((1 << CREDIT_W) - 1);
  localparam logic [CNT_W-1:0] THR_POS     = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] THR_NEG     = ~THR_POS + 1'b1;

  function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
    logic [CNT_W-1:0] b;
    b = g;
    for (int unsigned i = 1; i < CNT_W; i++) b = b ^ (g >> i);
    return b;
  endfunction

  logic [CNT_W-1:0] tx_bin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_bin <= '0;
    else     tx_bin <= gray2bin(tx_cnt_gray);
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    state_t             state;
    comp_type_t         ctype;
    logic [CNT_W-1:0]   rx_bin;
    logic [CNT_W-1:0]   baseline;
    logic [CNT_W-1:0]   reported;
    logic [SET_W-1:0]   settle_cnt;
    logic               vld;
    logic               ovf;
    logic [CREDIT_W-1:0] cnt;

    logic [CNT_W-1:0]    diff;
    logic [CNT_W-1:0]    d_cls;
    logic [CNT_W-1:0]    delta;
    logic                cls_yes;
    logic                cls_no;
    logic                delta_pos;
    logic                delta_big;
    logic [CREDIT_W-1:0] grant;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_bin <= '0;
      else     rx_bin <= gray2bin(rx_cnt_gray[g*CNT_W +: CNT_W]);
    end

    // All drift arithmetic is modulo 2^CNT_W; sign is taken from the MSB so
    // unsigned compares stay correct on either side of zero.
    always_comb begin
      diff      = tx_bin - rx_bin;
      d_cls     = diff - baseline;
      delta     = diff - reported;
      cls_yes   = !d_cls[CNT_W-1] && (d_cls >= THR_POS);
      cls_no    = d_cls[CNT_W-1] && (d_cls <= THR_NEG);
      delta_pos = !delta[CNT_W-1] && (delta != '0);
      delta_big = delta_pos && (delta > MAX_GRANT);
      grant     = delta_big ? '1 : delta[CREDIT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state      <= ST_IDLE;
        ctype      <= TYPE_UNKNOWN;
        baseline   <= '0;
        reported   <= '0;
        settle_cnt <= '0;
        vld        <= 1'b0;
        ovf        <= 1'b0;
        cnt        <= '0;
      end else if (!enable) begin
        state      <= ST_IDLE;
        vld        <= 1'b0;
        settle_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state      <= ST_SETTLE;
            ctype      <= TYPE_UNKNOWN;
            ovf        <= 1'b0;
            settle_cnt <= '0;
          end
          ST_SETTLE: begin
            if (settle_cnt == SETTLE_LAST) begin
              baseline <= diff;
              reported <= diff;
              case (mode)
                2'd1: begin
                  state <= ST_TRACK;
                  ctype <= TYPE_YES;
                end
                2'd2: begin
                  state <= ST_PASSIVE;
                  ctype <= TYPE_NO;
                end
                default: state <= ST_CLASSIFY;
              endcase
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          ST_CLASSIFY: begin
            if (cls_yes) begin
              state <= ST_TRACK;
              ctype <= TYPE_YES;
            end else if (cls_no) begin
              state <= ST_PASSIVE;
              ctype <= TYPE_NO;
            end
          end
          ST_TRACK: begin
            // A stalled grant freezes cnt and reported until it is accepted.
            if (!vld || comp_rdy[g]) begin
              if (delta_pos) begin
                cnt      <= grant;
                reported <= reported + CNT_W'(grant);
                vld      <= 1'b1;
                if (delta_big) ovf <= 1'b1;
              end else begin
                vld <= 1'b0;
              end
            end
          end
          ST_PASSIVE: ;
          default: state <= ST_IDLE;
        endcase
      end
    end

    assign comp_vld[g]                       = vld;
    assign comp_cnt[g*CREDIT_W +: CREDIT_W]  = cnt;
    assign comp_type[g*2 +: 2]               = ctype;
    assign overflow[g]                       = ovf;
  end

endmodule

// File: tb/tb_clock_compensate_multi.sv
// Directed bench for clock_compensate_multi: drift classification, credit grants,
// stall/overflow, counter wrap, force mode, enable drop and async reset.
module tb_clock_compensate_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] tx_cnt_gray;
  logic [63:0] rx_cnt_gray;
  logic [3:0]  comp_vld;
  logic [15:0] comp_cnt;
  logic [3:0]  comp_rdy;
  logic [7:0]  comp_type;
  logic [3:0]  overflow;

  int          tests = 0;
  int          failed = 0;
  logic [3:0]  vld_seen;
  logic        stall_ok;
  logic [15:0] tx;

  always #5 clk = ~clk;

  clock_compensate_multi #(
    .N_CH(4),
    .CNT_W(16),
    .CREDIT_W(4),
    .SETTLE(64),
    .THRESH(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .mode(mode),
    .tx_cnt_gray(tx_cnt_gray),
    .rx_cnt_gray(rx_cnt_gray),
    .comp_vld(comp_vld),
    .comp_cnt(comp_cnt),
    .comp_rdy(comp_rdy),
    .comp_type(comp_type),
    .overflow(overflow)
  );

  function automatic logic [15:0] b2g(input logic [15:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic set_cnt(input logic [15:0] t, input logic [15:0] r0, input logic [15:0] r1,
                         input logic [15:0] r2, input logic [15:0] r3);
    tx          = t;
    tx_cnt_gray = b2g(t);
    rx_cnt_gray = {b2g(r3), b2g(r2), b2g(r1), b2g(r0)};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    vld_seen = vld_seen | comp_vld;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    mode     = 2'd0;
    comp_rdy = 4'hF;
    vld_seen = '0;
    set_cnt(16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    ticks(3);
    check("rst_vld",  32'(comp_vld),  32'h0);
    check("rst_cnt",  32'(comp_cnt),  32'h0);
    check("rst_type", 32'(comp_type), 32'h0);
    check("rst_ovf",  32'(overflow),  32'h0);
    rst = 1'b0;
    ticks(2);

    // Identical counters, auto mode: nothing classified, no grants.
    enable   = 1'b1;
    vld_seen = '0;
    ticks(200);
    check("idle_vld_never", 32'(vld_seen),  32'h0);
    check("idle_type",      32'(comp_type), 32'h0);
    check("idle_ovf",       32'(overflow),  32'h0);

    // ch0 RX lags (fixed), ch1 RX leads by 3, ch2/ch3 follow TX.
    vld_seen = '0;
    set_cnt(16'h1235, 16'h1234, 16'h1238, 16'h1235, 16'h1235);
    ticks(10);
    check("ch1_passive_type", 32'(comp_type), 32'h08);
    check("d1_no_vld",        32'(comp_vld),  32'h0);

    set_cnt(16'h1236, 16'h1234, 16'h1239, 16'h1236, 16'h1236);
    tick();
    check("d2_type_pending", 32'(comp_type), 32'h08);
    tick();
    check("d2_type_yes",     32'(comp_type), 32'h09);
    check("d2_vld_lo",       32'(comp_vld),  32'h0);
    tick();
    check("d2_first_vld",    32'(comp_vld),  32'h1);
    check("d2_first_cnt",    32'(comp_cnt[3:0]), 32'h2);
    tick();
    check("d2_vld_drop",     32'(comp_vld),  32'h0);
    ticks(6);

    set_cnt(16'h1237, 16'h1234, 16'h123A, 16'h1237, 16'h1237);
    tick();
    check("lat_edge1",       32'(comp_vld),  32'h0);
    tick();
    check("lat_edge2_vld",   32'(comp_vld),  32'h1);
    check("lat_edge2_cnt",   32'(comp_cnt[3:0]), 32'h1);
    tick();
    check("lat_edge3_drop",  32'(comp_vld),  32'h0);
    ticks(7);
    check("only_ch0_vld",    32'(vld_seen),  32'h1);
    check("types_stable",    32'(comp_type), 32'h09);

    // Stall ch0 with one credit pending while drift grows by 20.
    comp_rdy = 4'b1110;
    set_cnt(16'h1238, 16'h1234, 16'h123B, 16'h1238, 16'h1238);
    ticks(2);
    check("stall_load_vld", 32'(comp_vld),  32'h1);
    check("stall_load_cnt", 32'(comp_cnt[3:0]), 32'h1);
    stall_ok = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (k < 40 && (k % 2) == 0) begin
        set_cnt(tx + 16'd1, 16'h1234, tx + 16'd4, tx + 16'd1, tx + 16'd1);
      end
      tick();
      if (!(comp_vld[0] === 1'b1 && comp_cnt[3:0] === 4'h1)) stall_ok = 1'b0;
    end
    check("stall_hold",    32'(stall_ok),    32'h1);
    check("stall_no_ovf",  32'(overflow),    32'h0);
    comp_rdy = 4'hF;
    tick();
    check("release_cnt15", 32'(comp_cnt[3:0]), 32'hF);
    check("release_vld",   32'(comp_vld),    32'h1);
    check("release_ovf",   32'(overflow),    32'h1);
    tick();
    check("remain_cnt5",   32'(comp_cnt[3:0]), 32'h5);
    check("remain_vld",    32'(comp_vld),    32'h1);
    tick();
    check("drained_vld",   32'(comp_vld),    32'h0);

    // Drop enable while a grant is stalled.
    comp_rdy = 4'b1110;
    set_cnt(tx + 16'd1, 16'h1234, tx + 16'd4, tx + 16'd1, tx + 16'd1);
    ticks(2);
    check("pre_dis_vld",   32'(comp_vld),  32'h1);
    enable = 1'b0;
    tick();
    check("dis_vld",       32'(comp_vld),  32'h0);
    check("dis_type_hold", 32'(comp_type), 32'h09);
    check("dis_ovf_hold",  32'(overflow),  32'h1);

    // Force-compensate mode with zero drift, counters parked near wrap.
    comp_rdy = 4'hF;
    mode     = 2'd1;
    set_cnt(16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE);
    ticks(2);
    enable = 1'b1;
    tick();
    check("reen_type_clr", 32'(comp_type), 32'h0);
    check("reen_ovf_clr",  32'(overflow),  32'h0);
    vld_seen = '0;
    ticks(63);
    check("settle_last",   32'(comp_type), 32'h0);
    tick();
    check("force_yes",     32'(comp_type), 32'h55);
    mode = 2'd0;
    ticks(20);
    check("force_no_vld",  32'(vld_seen),  32'h0);

    // TX wraps past 0xFFFF while ch0 RX sits at 0xFFFE.
    set_cnt(16'h0000, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000);
    tick();
    check("wrap_edge1",    32'(comp_vld),  32'h0);
    tick();
    check("wrap_vld",      32'(comp_vld),  32'h1);
    check("wrap_cnt2",     32'(comp_cnt[3:0]), 32'h2);
    check("wrap_no_ovf",   32'(overflow),  32'h0);
    tick();
    check("wrap_drop",     32'(comp_vld),  32'h0);

    // Asynchronous reset while a grant is stalled.
    comp_rdy = 4'b1110;
    set_cnt(16'h0001, 16'hFFFE, 16'h0001, 16'h0001, 16'h0001);
    ticks(3);
    check("pre_rst_vld",   32'(comp_vld),  32'h1);
    #3 rst = 1'b1;
    #1;
    check("arst_vld",      32'(comp_vld),  32'h0);
    check("arst_cnt",      32'(comp_cnt),  32'h0);
    check("arst_type",     32'(comp_type), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
